// File: rtl/ret_intr_sequencer_if.sv
// Bus between the return/interrupt sequencer and the core that drives it.
// The core side raises the requests and takes the stack, PC and bubble
// strobes. The sequencer side does the reverse.
interface ret_intr_sequencer_if #(
  parameter int SEG_W = 2
);
  logic             ret;
  logic             rti;
  logic             intr;
  logic             pop_en;
  logic [SEG_W-1:0] pop_segment;
  logic             write_pc;
  logic             restore_flags;
  logic             nop;
  logic             out_intr;
  logic             busy;

  // Core side: issues requests and consumes the strobes.
  modport master (
    output ret, rti, intr,
    input  pop_en, pop_segment, write_pc, restore_flags, nop, out_intr, busy
  );

  // Sequencer side: samples requests and produces the strobes.
  modport slave (
    input  ret, rti, intr,
    output pop_en, pop_segment, write_pc, restore_flags, nop, out_intr, busy
  );
endinterface

// File: rtl/ret_intr_sequencer.sv
// Return / return-from-interrupt sequencer.
// After a return is accepted, the block waits for a flush window. It then
// pops the PC words from the stack, one per cycle. An rti also pops one extra
// word holding the flags. The block then commits the PC (and the flags for an
// rti). An interrupt that arrives while a return is in flight is held as one
// pending flag. It fires after a short bubble once the write-back is done.
// All outputs are decoded from registered state only.
module ret_intr_sequencer #(
  parameter int POP_WORDS     = 2,
  parameter int FLUSH_CYCLES  = 1,
  parameter int BUBBLE_CYCLES = 1,
  parameter int SEG_W         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ret_intr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_POP,
    S_WB,
    S_BUBBLE,
    S_FIRE
  } state_t;

  typedef enum logic {
    MODE_RET,
    MODE_RTI
  } mode_t;

  // Last pop index. A plain return stops before the flags word, and an rti
  // includes the flags word.
  localparam logic [SEG_W-1:0] LAST_RET    = SEG_W'(POP_WORDS - 1);
  localparam logic [SEG_W-1:0] LAST_RTI    = SEG_W'(POP_WORDS);
  localparam logic [2:0]       FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0]       BUBBLE_LAST = 3'(BUBBLE_CYCLES - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             pending_q, pending_d;
  logic [SEG_W-1:0] idx_q, idx_d;
  logic [2:0]       wait_q, wait_d;

  logic [SEG_W-1:0] last_idx;
  assign last_idx = (mode_q == MODE_RTI) ? LAST_RTI : LAST_RET;

  // State register. Reset drops the block back to IDLE from anywhere.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge and no ordering
  // hazard exists between always_ff blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_RET;
      pending_q <= 1'b0;
      idx_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state logic. It also tracks the sticky pending interrupt.
  // NOTE: every variable gets its hold value before the case statement, so
  // any path that does not assign a variable keeps its old value and no
  // latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    wait_d    = wait_q;

    unique case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (bus.rti || bus.ret) begin
          // A return wins over a simultaneous interrupt. The interrupt
          // is remembered and fires after the return completes.
          state_d   = S_FLUSH;
          mode_d    = bus.rti ? MODE_RTI : MODE_RET;
          pending_d = bus.intr;
          idx_d     = '0;
          wait_d    = '0;
        end else if (bus.intr) begin
          state_d = S_FIRE;
        end
      end

      S_FLUSH: begin
        pending_d = pending_q | bus.intr;
        if (wait_q == FLUSH_LAST) begin
          state_d = S_POP;
          idx_d   = '0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_POP: begin
        pending_d = pending_q | bus.intr;
        if (idx_q == last_idx) begin
          state_d = S_WB;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + SEG_W'(1);
        end
      end

      S_WB: begin
        // An interrupt seen in this last cycle still counts, so it decides
        // the exit together with the stored flag.
        pending_d = pending_q | bus.intr;
        wait_d    = '0;
        state_d   = (pending_q | bus.intr) ? S_BUBBLE : S_IDLE;
      end

      S_BUBBLE: begin
        pending_d = pending_q | bus.intr;
        if (wait_q == BUBBLE_LAST) begin
          state_d = S_FIRE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_FIRE: begin
        pending_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
        idx_d     = '0;
        wait_d    = '0;
      end
    endcase
  end

  // Moore output decode. Every strobe is a pure function of the registers.
  always_comb begin
    bus.pop_en        = 1'b0;
    bus.pop_segment   = '0;
    bus.write_pc      = 1'b0;
    bus.restore_flags = 1'b0;
    bus.nop           = 1'b0;
    bus.out_intr      = 1'b0;
    bus.busy          = (state_q != S_IDLE);

    unique case (state_q)
      S_POP: begin
        bus.pop_en      = 1'b1;
        bus.pop_segment = idx_q;
      end
      S_WB: begin
        bus.write_pc      = 1'b1;
        bus.restore_flags = (mode_q == MODE_RTI);
      end
      S_BUBBLE: bus.nop      = 1'b1;
      S_FIRE:   bus.out_intr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/ret_intr_sequencer.md
RET_INTR_SEQUENCER -- requirements
Module: ret_intr_sequencer

Parameters
REQ-001 The block SHALL expose parameter POP_WORDS, default 2, meaning the number of stack words popped to rebuild the PC (legal range 1..8).
REQ-002 The block SHALL expose parameter FLUSH_CYCLES, default 1, meaning the wait cycles between accepting a return and the first pop (legal range 1..7).
REQ-003 The block SHALL expose parameter BUBBLE_CYCLES, default 1, meaning the nop cycles inserted before a deferred interrupt fires (legal range 1..7).
REQ-004 The block SHALL expose parameter SEG_W, default 2, meaning the pop_segment width, with 2^SEG_W >= POP_WORDS+1.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port ret, input, 1 bit: return request, sampled only in IDLE.
REQ-008 The block SHALL have port rti, input, 1 bit: return-from-interrupt request (PC words plus one flags word), sampled only in IDLE.
REQ-009 The block SHALL have port intr, input, 1 bit: external interrupt request, level, sampled every cycle.
REQ-010 The block SHALL have port pop_en, output, 1 bit: stack pop strobe, one word per cycle.
REQ-011 The block SHALL have port pop_segment, output, SEG_W bits: index of the word being popped.
REQ-012 The block SHALL have port write_pc, output, 1 bit: commit the assembled PC (one-cycle pulse).
REQ-013 The block SHALL have port restore_flags, output, 1 bit: commit the popped flags (rti only, one-cycle pulse).
REQ-014 The block SHALL have port nop, output, 1 bit: force a pipeline bubble.
REQ-015 The block SHALL have port out_intr, output, 1 bit: start interrupt entry (one-cycle pulse).
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL implement the states IDLE, FLUSH, POP, WB, BUBBLE and FIRE, with all outputs decoded from registered state only (Moore) and no combinational path from any input to any output.
REQ-018 In IDLE, rti=1 SHALL move the block to FLUSH with mode=RTI; otherwise ret=1 SHALL move it to FLUSH with mode=RET. rti takes priority over ret.
REQ-019 In IDLE with intr=1 and no ret/rti, the block SHALL move to FIRE.
REQ-020 In IDLE with intr=1 and ret or rti also high, the return SHALL win and the pending flag SHALL be set.
REQ-021 FLUSH SHALL last exactly FLUSH_CYCLES cycles with all strobes low, then the block SHALL move to POP with index 0.
REQ-022 In POP, pop_en SHALL be 1 and pop_segment SHALL equal the index, which increments by 1 per cycle.
REQ-023 POP SHALL last POP_WORDS cycles for RET and POP_WORDS+1 cycles for RTI (last index = POP_WORDS, the flags word), then the block SHALL move to WB.
REQ-024 In WB, write_pc SHALL be 1 and restore_flags SHALL be 1 if and only if mode=RTI, for exactly one cycle.
REQ-025 After WB, the block SHALL move to BUBBLE if pending=1, else to IDLE.
REQ-026 BUBBLE SHALL hold nop=1 for exactly BUBBLE_CYCLES cycles, then the block SHALL move to FIRE.
REQ-027 FIRE SHALL assert out_intr=1 for one cycle, clear pending and return to IDLE; out_intr SHALL never be high in two consecutive cycles.
REQ-028 intr=1 sampled in FLUSH, POP, WB or BUBBLE SHALL set pending (sticky until FIRE); repeated intr SHALL NOT queue a second interrupt.
REQ-029 ret/rti asserted outside IDLE SHALL be ignored, not queued.
REQ-030 Outside their states, pop_en, write_pc, restore_flags, nop and out_intr SHALL be 0, and pop_segment SHALL be 0.
REQ-031 Latency: with a return sampled at edge E0, the first pop_en SHALL appear after edge E0+FLUSH_CYCLES and write_pc after edge E0+FLUSH_CYCLES+Nw, where Nw is the number of popped words.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, clear pending, mode and index, and drive all outputs to 0, including in the middle of any sequence.
REQ-033 After rst rises, the first edge SHALL evaluate IDLE transitions normally.

Verification
REQ-034 Defaults, ret pulse at E0 -> pop_en high on cycles E1+1..E1+2 with pop_segment 0 then 1; write_pc in the next cycle; busy low after WB; restore_flags stays 0.
REQ-035 Defaults, rti pulse -> three pops with pop_segment 0, 1, 2; write_pc=1 and restore_flags=1 together for one cycle.
REQ-036 ret and intr together in IDLE -> full RET sequence, then nop=1 for 1 cycle, then out_intr=1 for 1 cycle, then IDLE.
REQ-037 intr held high through an entire rti sequence -> exactly one out_intr pulse after the bubble; ret pulsed mid-sequence produces no second sequence.
REQ-038 rst driven low during the second POP cycle -> all outputs 0 asynchronously; a later intr alone produces out_intr on the cycle after the sampling edge, with no stale pending.
REQ-039 POP_WORDS=4, FLUSH_CYCLES=3, BUBBLE_CYCLES=2, SEG_W=3 with rti and intr -> 3 flush cycles, pop_segment 0..4, WB, 2 nop cycles, then out_intr.
